spi_sensor_reader: RTL and testbench
====================================

// Module: spi_sensor_reader
// PURPOSE
//  Parametrised successor to the gyro reader: drives a byte-level SPI master (begin/end_transmission
//  handshake) to configure one SPI sensor, then periodically burst-reads NUM_AXES multi-byte samples.
//  Sits between the SPI master and sensor consumers; publishes each burst atomically with a valid strobe.
//  Adds a transfer timeout with an error flag, correct per-burst slave select and a busy flag.
// PARAMETERS
//  NUM_AXES        3         axes per burst (1..8)
//  BYTES_PER_AXIS  2         bytes per axis (1..4); AXIS_W = 8*BYTES_PER_AXIS
//  CFG_ADDR        8'h20     config register address (write: bit7=0, bit6=0)
//  CFG_VALUE       8'h0F     value written to CFG_ADDR
//  DATA_ADDR       8'h28     first data register; burst command = 8'hC0 | DATA_ADDR[5:0]
//  SS_GAP          4095      cycles slave_select held high between transactions (>=1)
//  SAMPLE_PERIOD   8388607   cycles from end of one burst's SS gap to next burst (>=1)
//  TIMEOUT         65535     max cycles waiting for end_transmission before abort
// PORTS
//  clk                 in   1                  system clock, all logic on rising edge
//  rst                 in   1                  asynchronous, active-low reset
//  start               in   1                  level; high = run, low = stop after current transaction
//  end_transmission    in   1                  1-cycle pulse from SPI master: byte done
//  recieved_data       in   8                  byte shifted in; valid when end_transmission=1
//  begin_transmission  out  1                  1-cycle pulse: SPI master sends send_data
//  send_data           out  8                  byte to transmit; valid with begin_transmission
//  slave_select        out  1                  active-low sensor chip select
//  axis_data           out  NUM_AXES*AXIS_W    axis k at [k*AXIS_W +: AXIS_W]
//  data_valid          out  1                  1-cycle pulse: axis_data updated
//  busy                out  1                  high whenever state != IDLE
//  error               out  1                  sticky: timeout occurred; cleared on rising edge of start
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, slave_select=1, begin_transmission=0, send_data=0, axis_data=0,
//   data_valid=0, busy=0, error=0, all counters 0. Effective immediately, including mid-transaction.
//  States: IDLE, CFG, READ, XFER_WAIT, GAP, PERIOD.
//  IDLE: ss=1. start=1 -> CFG (config is rewritten on every start).
//  CFG: ss=0; sends CFG_ADDR then CFG_VALUE, each via XFER_WAIT; after 2nd byte -> GAP.
//  READ: ss=0; sends burst command, then NUM_AXES*BYTES_PER_AXIS bytes of 8'h00, each via XFER_WAIT.
//  XFER_WAIT: begin_transmission pulses exactly 1 cycle on entry; waits for end_transmission;
//   next begin_transmission no earlier than 1 cycle after end_transmission. Timer counts from entry;
//   reaching TIMEOUT -> ss=1, error=1, -> IDLE (shadow data discarded, no data_valid).
//  Data capture: byte n (n=0 first after command) -> shadow axis n/BYTES_PER_AXIS,
//   byte slot n%BYTES_PER_AXIS; little-endian (slot 0 = LSBs). Command-phase byte ignored.
//  After last data byte: axis_data <= shadow and data_valid=1 in the same cycle; -> GAP.
//  GAP: ss=1 for exactly SS_GAP cycles, -> PERIOD (after CFG or READ alike).
//  PERIOD: counts SAMPLE_PERIOD cycles, -> READ. start=0 in GAP or PERIOD -> IDLE next cycle.
//  start=0 during CFG/READ/XFER_WAIT: transaction completes (incl. data_valid), then GAP -> IDLE.
//  end_transmission outside XFER_WAIT: ignored. end_transmission on the same cycle as timeout
//   expiry: byte accepted, no error.
//  Counters sized by $clog2; byte counter never wraps (bounded by burst length).
//  axis_data holds last valid burst until next data_valid or reset.
// CONFIGURATION
//  SENSOR_TEMP_EN defined: adds port temp_data out 8 (reset 0) and temp_valid out 1; after each
//   data burst's GAP, a temperature transaction (cmd 8'hA6, one 8'h00 dummy; 2nd received byte
//   -> temp_data, temp_valid 1-cycle pulse) runs, then GAP, then PERIOD.
//  Undefined: no temp ports, no temperature transaction; bursts separated by GAP+PERIOD only.
// TESTING (SS_GAP=4, SAMPLE_PERIOD=8, TIMEOUT=32, model SPI master replies 5 cycles after begin)
//  Reset/start: rst=0 -> all outputs reset values; start=1 -> sends 8'h20,8'h0F with ss=0, then ss=1 for 4 cycles.
//  Burst: replies 11,22,33,44,55,66 -> send_data 8'hE8 then six 8'h00; axis_data = {16'h6655,16'h4433,16'h2211}, data_valid once.
//  Timeout: model withholds end_transmission -> 32 cycles later error=1, ss=1, IDLE, no data_valid; start toggle clears error.
//  Stop mid-burst: start=0 after 2nd data byte -> burst completes, data_valid=1, GAP, then busy=0.
//  Async reset mid-XFER_WAIT: rst=0 -> ss=1, begin_transmission=0, axis_data=0 without clk edge.
//  SENSOR_TEMP_EN: temp reply 8'h19 -> send_data 8'hA6,8'h00, temp_data=8'h19, temp_valid one pulse.

Source files
------------

// File: rtl/spi_sensor_reader_if.sv
// ---------------------------------------------------------------------------
// spi_sensor_reader_if
// Byte-level handshake between the sensor reader and a byte-oriented SPI
// master, plus the sensor chip select.
//
// Signals
//   begin_transmission  reader -> SPI master  1-cycle pulse, send send_data
//   send_data[7:0]      reader -> SPI master  byte to shift out
//   slave_select        reader -> sensor      active-low chip select
//   end_transmission    SPI master -> reader  1-cycle pulse, byte finished
//   recieved_data[7:0]  SPI master -> reader  byte shifted in
//
// Modports
//   master : the sensor reader side (drives the handshake requests)
//   slave  : the SPI master / bench side (answers the requests)
// ---------------------------------------------------------------------------
interface spi_sensor_reader_if;
  logic       begin_transmission;
  logic [7:0] send_data;
  logic       slave_select;
  logic       end_transmission;
  logic [7:0] recieved_data;

  modport master (
    output begin_transmission,
    output send_data,
    output slave_select,
    input  end_transmission,
    input  recieved_data
  );

  modport slave (
    input  begin_transmission,
    input  send_data,
    input  slave_select,
    output end_transmission,
    output recieved_data
  );
endinterface

// File: rtl/spi_sensor_reader.sv
// ---------------------------------------------------------------------------
// spi_sensor_reader
// Configures one SPI sensor through a byte-level SPI master, then burst-reads
// NUM_AXES samples of BYTES_PER_AXIS bytes every sample period and publishes
// each complete burst atomically on axis_data with a data_valid strobe.
// A stalled byte transfer is aborted after TIMEOUT cycles and flagged on the
// sticky error output.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       level: high = run, low = stop after the current transaction
//   spi         byte handshake to the SPI master (master modport)
//   axis_data   axis k at [k*AXIS_W +: AXIS_W], little-endian bytes
//   data_valid  1-cycle pulse when axis_data is updated
//   busy        high whenever the controller is not idle
//   error       sticky timeout flag, cleared on a rising edge of start
//   temp_data   (SENSOR_TEMP_EN only) last temperature byte
//   temp_valid  (SENSOR_TEMP_EN only) 1-cycle pulse when temp_data updates
//
// Build option
//   SENSOR_TEMP_EN : after each data burst's gap, run a temperature read
//                    (command 8'hA6 plus one dummy byte) before the period.
// ---------------------------------------------------------------------------
module spi_sensor_reader #(
  parameter int         NUM_AXES       = 3,
  parameter int         BYTES_PER_AXIS = 2,
  parameter logic [7:0] CFG_ADDR       = 8'h20,
  parameter logic [7:0] CFG_VALUE      = 8'h0F,
  parameter logic [7:0] DATA_ADDR      = 8'h28,
  parameter int         SS_GAP         = 4095,
  parameter int         SAMPLE_PERIOD  = 8388607,
  parameter int         TIMEOUT        = 65535
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  spi_sensor_reader_if.master                  spi,
  output logic [NUM_AXES*8*BYTES_PER_AXIS-1:0] axis_data,
  output logic                                 data_valid,
  output logic                                 busy,
  output logic                                 error
`ifdef SENSOR_TEMP_EN
  ,
  output logic [7:0]                           temp_data,
  output logic                                 temp_valid
`endif
);

  localparam int TOTAL    = NUM_AXES * BYTES_PER_AXIS;
  localparam int DATA_W   = 8 * TOTAL;
  localparam int CNT_W    = $clog2(TOTAL + 2);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);
  localparam int WAIT_MAX = (SS_GAP > SAMPLE_PERIOD) ? SS_GAP : SAMPLE_PERIOD;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  // Auto-increment burst read: read bit and multi-byte bit set on top of the address
  localparam logic [7:0] BURST_CMD = 8'hC0 | {2'b00, DATA_ADDR[5:0]};

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CFG       = 3'd1;
  localparam logic [2:0] READ      = 3'd2;
  localparam logic [2:0] XFER_WAIT = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] PERIOD    = 3'd5;
`ifdef SENSOR_TEMP_EN
  localparam logic [2:0] TEMP      = 3'd6;
`endif

  logic [2:0]        state;
  logic [2:0]        ret_state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMR_W-1:0]  timer;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] merged;
  logic              last_data;
  logic              begin_q;
  logic [7:0]        send_q;
  logic              ss_q;
  logic              start_d;
`ifdef SENSOR_TEMP_EN
  logic              temp_next;
`endif

  assign spi.begin_transmission = begin_q;
  assign spi.send_data          = send_q;
  assign spi.slave_select       = ss_q;
  assign busy                   = (state != IDLE);

  // byte_cnt counts the command byte as 0, so data byte n arrives with
  // byte_cnt == n+1 and lands at bit 8*n; little-endian per axis falls out.
  always_comb begin
    merged = shadow;
    for (int i = 0; i < TOTAL; i++) begin
      if (byte_cnt == CNT_W'(i + 1)) begin
        merged[i*8 +: 8] = spi.recieved_data;
      end
    end
  end

  assign last_data = (byte_cnt == CNT_W'(TOTAL));

  // Main controller: each byte is launched from CFG/READ(/TEMP) and then
  // handed to XFER_WAIT, which returns to ret_state once the byte is done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      byte_cnt   <= '0;
      timer      <= '0;
      wait_cnt   <= '0;
      shadow     <= '0;
      begin_q    <= 1'b0;
      send_q     <= 8'h00;
      ss_q       <= 1'b1;
      start_d    <= 1'b0;
      axis_data  <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
`ifdef SENSOR_TEMP_EN
      temp_next  <= 1'b0;
      temp_data  <= 8'h00;
      temp_valid <= 1'b0;
`endif
    end else begin
      begin_q    <= 1'b0;
      data_valid <= 1'b0;
      start_d    <= start;
`ifdef SENSOR_TEMP_EN
      temp_valid <= 1'b0;
`endif
      if (start && !start_d) begin
        error <= 1'b0;
      end

      case (state)
        IDLE: begin
          ss_q     <= 1'b1;
          byte_cnt <= '0;
`ifdef SENSOR_TEMP_EN
          temp_next <= 1'b0;
`endif
          if (start) begin
            state <= CFG;
          end
        end

        CFG: begin
          ss_q      <= 1'b0;
          begin_q   <= 1'b1;
          send_q    <= (byte_cnt == '0) ? CFG_ADDR : CFG_VALUE;
          ret_state <= CFG;
          timer     <= '0;
          state     <= XFER_WAIT;
        end

        READ: begin
          ss_q      <= 1'b0;
          begin_q   <= 1'b1;
          send_q    <= (byte_cnt == '0) ? BURST_CMD : 8'h00;
          ret_state <= READ;
          timer     <= '0;
          state     <= XFER_WAIT;
        end

`ifdef SENSOR_TEMP_EN
        TEMP: begin
          ss_q      <= 1'b0;
          begin_q   <= 1'b1;
          send_q    <= (byte_cnt == '0) ? 8'hA6 : 8'h00;
          ret_state <= TEMP;
          timer     <= '0;
          state     <= XFER_WAIT;
        end
`endif

        XFER_WAIT: begin
          // A byte completing on the expiry cycle still counts as a success
          if (spi.end_transmission) begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ret_state;
            case (ret_state)
              CFG: begin
                if (byte_cnt == CNT_W'(1)) begin
                  state    <= GAP;
                  ss_q     <= 1'b1;
                  wait_cnt <= '0;
                  byte_cnt <= '0;
                end
              end
              READ: begin
                shadow <= merged;
                if (last_data) begin
                  axis_data  <= merged;
                  data_valid <= 1'b1;
                  state      <= GAP;
                  ss_q       <= 1'b1;
                  wait_cnt   <= '0;
                  byte_cnt   <= '0;
`ifdef SENSOR_TEMP_EN
                  temp_next  <= 1'b1;
`endif
                end
              end
`ifdef SENSOR_TEMP_EN
              TEMP: begin
                if (byte_cnt == CNT_W'(1)) begin
                  temp_data  <= spi.recieved_data;
                  temp_valid <= 1'b1;
                  state      <= GAP;
                  ss_q       <= 1'b1;
                  wait_cnt   <= '0;
                  byte_cnt   <= '0;
                end
              end
`endif
              default: state <= IDLE;
            endcase
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            ss_q     <= 1'b1;
            error    <= 1'b1;
            state    <= IDLE;
            byte_cnt <= '0;
            shadow   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (!start) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_W'(SS_GAP - 1)) begin
            wait_cnt <= '0;
            byte_cnt <= '0;
`ifdef SENSOR_TEMP_EN
            temp_next <= 1'b0;
            state     <= temp_next ? TEMP : PERIOD;
`else
            state     <= PERIOD;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        PERIOD: begin
          if (!start) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_W'(SAMPLE_PERIOD - 1)) begin
            wait_cnt <= '0;
            byte_cnt <= '0;
            state    <= READ;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_sensor_reader
// Self-checking bench for spi_sensor_reader with SS_GAP=4, SAMPLE_PERIOD=8,
// TIMEOUT=32. A model SPI master answers each begin_transmission 5 cycles
// later with the next byte of reply_q. Expected transmitted bytes and
// expected bursts are queued when a transaction is set up and compared as
// the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spi_sensor_reader;

  localparam int AXES = 3;
  localparam int BPA  = 2;
  localparam int DW   = AXES * BPA * 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] axis_data;
  logic          data_valid;
  logic          busy;
  logic          error;
`ifdef SENSOR_TEMP_EN
  logic [7:0]    temp_data;
  logic          temp_valid;
  int            tv_count = 0;
  logic          prev_tv  = 1'b0;
`endif

  spi_sensor_reader_if spi ();

  spi_sensor_reader #(
    .NUM_AXES      (AXES),
    .BYTES_PER_AXIS(BPA),
    .SS_GAP        (4),
    .SAMPLE_PERIOD (8),
    .TIMEOUT       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .spi       (spi),
    .axis_data (axis_data),
    .data_valid(data_valid),
    .busy      (busy),
    .error     (error)
`ifdef SENSOR_TEMP_EN
    ,
    .temp_data (temp_data),
    .temp_valid(temp_valid)
`endif
  );

  logic [7:0]    exp_send_q[$];
  logic [7:0]    reply_q[$];
  logic [DW-1:0] exp_axis_q[$];

  int   n_checks       = 0;
  int   n_fail         = 0;
  int   cyc            = 0;
  int   last_begin_cyc = 0;
  int   dv_count       = 0;
  logic prev_begin     = 1'b0;
  logic withhold       = 1'b0;

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queues one full start-up: config write, then one burst whose data replies
  // are given little-endian (reply byte n at bits 8n), which is also the
  // expected axis_data image.
  task automatic applyStimulus(input logic [DW-1:0] replies);
    exp_send_q.push_back(8'h20);
    exp_send_q.push_back(8'h0F);
    reply_q.push_back(8'hA5);
    reply_q.push_back(8'h5A);
    exp_send_q.push_back(8'hE8);
    reply_q.push_back(8'hC3);
    for (int i = 0; i < AXES * BPA; i++) begin
      exp_send_q.push_back(8'h00);
      reply_q.push_back(replies[i*8 +: 8]);
    end
    exp_axis_q.push_back(replies);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model SPI master: replies 5 cycles after each begin_transmission unless
  // the bench is deliberately withholding the reply.
  initial begin
    spi.end_transmission = 1'b0;
    spi.recieved_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (spi.begin_transmission && !withhold) begin
        repeat (5) @(negedge clk);
        spi.recieved_data    = (reply_q.size() > 0) ? reply_q.pop_front() : 8'h00;
        spi.end_transmission = 1'b1;
        @(negedge clk);
        spi.end_transmission = 1'b0;
      end
    end
  end

  // Monitor: scoreboards every transmitted byte and every published burst
  always @(negedge clk) begin
    cyc++;
    if (spi.begin_transmission) begin
      checkOutput("begin_single_cycle", prev_begin, 1'b0);
      checkOutput("ss_low_on_send", spi.slave_select, 1'b0);
      checkOutput("send_expected", exp_send_q.size() > 0, 1'b1);
      if (exp_send_q.size() > 0) begin
        checkOutput("send_data", spi.send_data, exp_send_q.pop_front());
      end
      last_begin_cyc = cyc;
    end
    prev_begin = spi.begin_transmission;
    if (data_valid) begin
      dv_count++;
      checkOutput("valid_expected", exp_axis_q.size() > 0, 1'b1);
      if (exp_axis_q.size() > 0) begin
        checkOutput("axis_data", axis_data, exp_axis_q.pop_front());
      end
    end
`ifdef SENSOR_TEMP_EN
    if (temp_valid) begin
      tv_count++;
      checkOutput("temp_single_pulse", prev_tv, 1'b0);
    end
    prev_tv = temp_valid;
`endif
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int dv_before;
    rst   = 1'b1;
    start = 1'b0;
    #3 rst = 1'b0;

    // Reset values
    tick();
    checkOutput("rst_ss", spi.slave_select, 1'b1);
    checkOutput("rst_begin", spi.begin_transmission, 1'b0);
    checkOutput("rst_send", spi.send_data, 8'h00);
    checkOutput("rst_axis", axis_data, '0);
    checkOutput("rst_valid", data_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_error", error, 1'b0);

    // Config then first burst
    $display("[TB] config and first burst");
    tick();
    rst = 1'b1;
    applyStimulus(48'h665544332211);
    start = 1'b1;
    n = 0;
    while (spi.slave_select && n < 20) begin tick(); n++; end
    checkOutput("cfg_ss_low", spi.slave_select, 1'b0);
    n = 0;
    while (!spi.slave_select && n < 40) begin tick(); n++; end
    checkOutput("cfg_ss_release", spi.slave_select, 1'b1);
    checkOutput("cfg_bytes_done", exp_send_q.size(), 7);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("gap_ss_high", spi.slave_select, 1'b1);
      checkOutput("gap_busy", busy, 1'b1);
    end
    n = 0;
    while (dv_count < 1 && n < 200) begin tick(); n++; end
    checkOutput("burst1_valid_count", dv_count, 1);
    start = 1'b0;
    checkOutput("burst1_axis_value", axis_data, 48'h665544332211);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    checkOutput("stop_busy_low", busy, 1'b0);
    checkOutput("burst1_all_sent", exp_send_q.size(), 0);
    tick();
    checkOutput("burst1_single_valid", dv_count, 1);

    // Timeout: the model never answers the first config byte
    $display("[TB] timeout");
    withhold = 1'b1;
    exp_send_q.push_back(8'h20);
    dv_before = dv_count;
    start = 1'b1;
    n = 0;
    while (!error && n < 80) begin tick(); n++; end
    start = 1'b0;
    checkOutput("timeout_error", error, 1'b1);
    checkOutput("timeout_latency_ok", (cyc - last_begin_cyc >= 32) && (cyc - last_begin_cyc <= 34), 1'b1);
    checkOutput("timeout_ss", spi.slave_select, 1'b1);
    checkOutput("timeout_idle", busy, 1'b0);
    checkOutput("timeout_no_valid", dv_count, dv_before);
    repeat (5) tick();
    checkOutput("error_sticky", error, 1'b1);
    withhold = 1'b0;

    // Restart clears error; stop is requested in the middle of the burst
    $display("[TB] stop mid-burst");
    applyStimulus(48'h060504030201);
    start = 1'b1;
    tick();
    checkOutput("error_cleared", error, 1'b0);
    n = 0;
    while (exp_send_q.size() > 4 && n < 200) begin tick(); n++; end
    checkOutput("midburst_reached", exp_send_q.size(), 4);
    start = 1'b0;
    dv_before = dv_count;
    n = 0;
    while (dv_count == dv_before && n < 100) begin tick(); n++; end
    checkOutput("stop_burst_valid", dv_count, dv_before + 1);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    checkOutput("stop2_busy_low", busy, 1'b0);
    checkOutput("stop2_ss_high", spi.slave_select, 1'b1);
    checkOutput("stop2_all_sent", exp_send_q.size(), 0);
    checkOutput("axis_hold", axis_data, 48'h060504030201);

    // Asynchronous reset in the middle of a data byte transfer
    $display("[TB] async reset");
    applyStimulus(48'hF0E0D0C0B0A0);
    start = 1'b1;
    n = 0;
    while (exp_send_q.size() > 5 && n < 200) begin tick(); n++; end
    checkOutput("areset_point", exp_send_q.size(), 5);
    checkOutput("areset_ss_before", spi.slave_select, 1'b0);
    checkOutput("areset_axis_before", axis_data, 48'h060504030201);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("areset_ss", spi.slave_select, 1'b1);
    checkOutput("areset_begin", spi.begin_transmission, 1'b0);
    checkOutput("areset_axis", axis_data, '0);
    checkOutput("areset_busy", busy, 1'b0);
    exp_send_q.delete();
    exp_axis_q.delete();
    repeat (10) tick();
    reply_q.delete();
    rst = 1'b1;
    tick();

`ifdef SENSOR_TEMP_EN
    // Temperature transaction after the data burst's gap
    $display("[TB] temperature read");
    applyStimulus(48'h0C0B0A090807);
    exp_send_q.push_back(8'hA6);
    exp_send_q.push_back(8'h00);
    reply_q.push_back(8'h77);
    reply_q.push_back(8'h19);
    start = 1'b1;
    n = 0;
    while (tv_count < 1 && n < 300) begin tick(); n++; end
    start = 1'b0;
    checkOutput("temp_valid_count", tv_count, 1);
    checkOutput("temp_data", temp_data, 8'h19);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    checkOutput("temp_busy_low", busy, 1'b0);
    checkOutput("temp_all_sent", exp_send_q.size(), 0);
`endif

    checkOutput("no_pending_bursts", exp_axis_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
